// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the store buffer. Entry widths follow the package
// constants, so top-level width parameters are expected to keep their defaults.
package store_buffer_pkg;
  localparam int STB_ADDR_W = 32;
  localparam int STB_DATA_W = 32;
  localparam int STB_SEL_W  = STB_DATA_W / 8;
  localparam int STB_DEPTH  = 8;
  localparam int PTR_W      = $clog2(STB_DEPTH);
  localparam int WOFF_W     = $clog2(STB_SEL_W);

  typedef struct packed {
    logic [STB_ADDR_W-1:0] addr;
    logic [STB_DATA_W-1:0] data;
    logic [STB_SEL_W-1:0]  sel;
  } stb_entry_t;

  function automatic logic word_match(input logic [STB_ADDR_W-1:0] a,
                                      input logic [STB_ADDR_W-1:0] b);
    return a[STB_ADDR_W-1:WOFF_W] == b[STB_ADDR_W-1:WOFF_W];
  endfunction
endpackage

// File: rtl/stb_fwd_merge.sv
// Combinational store-to-load forwarding: per byte, the youngest valid entry
// matching the load word with that byte enabled supplies the data.
module stb_fwd_merge
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = STB_DEPTH
) (
  input  stb_entry_t [DEPTH-1:0]          entries,
  input  logic [PTR_W-1:0]                head,
  input  logic [PTR_W:0]                  count,
  input  logic [STB_ADDR_W-1:0]           ld_addr,
  output logic [STB_SEL_W-1:0]            fwd_mask,
  output logic [STB_SEL_W-1:0][7:0]       fwd_data
);
  stb_entry_t [DEPTH-1:0] age;
  logic [DEPTH-1:0]       hit;

  // age[0] is the oldest entry, so later hits override earlier ones
  always_comb begin
    age = '0;
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age[i] = entries[head + PTR_W'(i)];
      hit[i] = ((PTR_W+1)'(i) < count) && word_match(age[i].addr, ld_addr);
    end
  end

  always_comb begin
    fwd_mask = '0;
    fwd_data = '0;
    for (int b = 0; b < STB_SEL_W; b++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (hit[i] && age[i].sel[b]) begin
          fwd_mask[b] = 1'b1;
          fwd_data[b] = age[i].data[8*b +: 8];
        end
      end
    end
  end
endmodule

// File: rtl/store_buffer_fwd.sv
// In-order store buffer with dcache drain, fence and byte-merged load forwarding.
// Define STB_COALESCE_EN to merge same-word stores into the youngest non-head entry.
module store_buffer_fwd
  import store_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH     = STB_ADDR_W,
  parameter int DATA_WIDTH     = STB_DATA_W,
  parameter int BYTE_SEL_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH          = STB_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     lsummu2stb_addr,
  input  logic [DATA_WIDTH-1:0]     lsummu2stb_wdata,
  input  logic [BYTE_SEL_WIDTH-1:0] lsummu2stb_sel_byte,
  input  logic                      lsummu2stb_w_en,
  input  logic                      lsummu2stb_req,
  input  logic                      dmem_sel_i,
  input  logic                      lsummu2stb_fence,
  input  logic [ADDR_WIDTH-1:0]     lsummu2stb_ld_addr,
  output logic                      stb2lsummu_ack,
  output logic                      stb2lsummu_stall,
  output logic [BYTE_SEL_WIDTH-1:0] stb2lsummu_fwd_mask,
  output logic [DATA_WIDTH-1:0]     stb2lsummu_fwd_data,
  output logic [ADDR_WIDTH-1:0]     stb2dcache_addr,
  output logic [DATA_WIDTH-1:0]     stb2dcache_wdata,
  output logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte,
  output logic                      stb2dcache_w_en,
  output logic                      stb2dcache_req,
  output logic                      stb2dcache_empty,
  output logic                      dmem_sel_o,
  output logic [$clog2(DEPTH):0]    stb_count,
  input  logic                      dcache2stb_ack
);
  stb_entry_t [DEPTH-1:0] entries;
  logic [PTR_W-1:0]       head, tail;
  logic [PTR_W:0]         count;
  logic                   full, empty, cand, push, pop, alloc;
  stb_entry_t             head_e, new_e;
  logic [BYTE_SEL_WIDTH-1:0][7:0] fwd_bytes;

  assign full  = count == (PTR_W+1)'(DEPTH);
  assign empty = count == '0;
  assign cand  = lsummu2stb_req & lsummu2stb_w_en & dmem_sel_i;
  assign new_e = '{addr: lsummu2stb_addr, data: lsummu2stb_wdata, sel: lsummu2stb_sel_byte};

`ifdef STB_COALESCE_EN
  logic [PTR_W-1:0] young;
  logic             merge_hit, merge;
  stb_entry_t       merged_e;

  assign young     = tail - PTR_W'(1);
  assign merge_hit = (count >= (PTR_W+1)'(2)) && word_match(entries[young].addr, lsummu2stb_addr);
  assign stb2lsummu_stall = lsummu2stb_fence | (full & ~merge_hit);
  assign merge = push & merge_hit;
  assign alloc = push & ~merge_hit;

  always_comb begin
    merged_e      = entries[young];
    merged_e.sel  = entries[young].sel | lsummu2stb_sel_byte;
    for (int b = 0; b < BYTE_SEL_WIDTH; b++)
      if (lsummu2stb_sel_byte[b]) merged_e.data[8*b +: 8] = lsummu2stb_wdata[8*b +: 8];
  end
`else
  assign stb2lsummu_stall = lsummu2stb_fence | full;
  assign alloc = push;
`endif

  // a store presented during reset is not acknowledged
  assign push = cand & ~stb2lsummu_stall & ~rst;
  assign pop  = ~empty & dcache2stb_ack;
  assign stb2lsummu_ack = push;

  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      entries <= '0;
    end else begin
      if (pop) head <= head + PTR_W'(1);
      if (alloc) begin
        entries[tail] <= new_e;
        tail          <= tail + PTR_W'(1);
      end
`ifdef STB_COALESCE_EN
      if (merge) entries[young] <= merged_e;
`endif
      case ({alloc, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_e              = entries[head];
  assign stb2dcache_addr     = empty ? '0 : head_e.addr;
  assign stb2dcache_wdata    = empty ? '0 : head_e.data;
  assign stb2dcache_sel_byte = empty ? '0 : head_e.sel;
  assign stb2dcache_req      = ~empty;
  assign stb2dcache_w_en     = ~empty;
  assign dmem_sel_o          = ~empty;
  assign stb2dcache_empty    = empty;
  assign stb_count           = count;

  stb_fwd_merge #(.DEPTH(DEPTH)) u_fwd (
    .entries  (entries),
    .head     (head),
    .count    (count),
    .ld_addr  (lsummu2stb_ld_addr),
    .fwd_mask (stb2lsummu_fwd_mask),
    .fwd_data (fwd_bytes)
  );
  assign stb2lsummu_fwd_data = fwd_bytes;
endmodule

// File: tb/tb_store_buffer_fwd.sv
// Randomized and directed bench for store_buffer_fwd against a queue-based model.
module tb_store_buffer_fwd;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, ld_addr;
  logic [3:0]  sel;
  logic        w_en, req, dsel_i, fence, dack;
  logic        ack, stall, dc_w_en, dc_req, dc_empty, dsel_o;
  logic [3:0]  fwd_mask, dc_sel;
  logic [31:0] fwd_data, dc_addr, dc_wdata;
  logic [3:0]  count;

  store_buffer_fwd dut (
    .clk(clk), .rst(rst),
    .lsummu2stb_addr(addr), .lsummu2stb_wdata(wdata), .lsummu2stb_sel_byte(sel),
    .lsummu2stb_w_en(w_en), .lsummu2stb_req(req), .dmem_sel_i(dsel_i),
    .lsummu2stb_fence(fence), .lsummu2stb_ld_addr(ld_addr),
    .stb2lsummu_ack(ack), .stb2lsummu_stall(stall),
    .stb2lsummu_fwd_mask(fwd_mask), .stb2lsummu_fwd_data(fwd_data),
    .stb2dcache_addr(dc_addr), .stb2dcache_wdata(dc_wdata), .stb2dcache_sel_byte(dc_sel),
    .stb2dcache_w_en(dc_w_en), .stb2dcache_req(dc_req), .stb2dcache_empty(dc_empty),
    .dmem_sel_o(dsel_o), .stb_count(count), .dcache2stb_ack(dack)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] s; } st_t;
  st_t q[$];

  int n_cmp = 0, n_err = 0;
  logic [31:0] o_fwd_data, o_dc_addr;
  logic [3:0]  o_fwd_mask, o_count;
  logic        o_ack, o_stall, o_empty, o_req;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: drive, check every output against the model, then advance the model.
  task automatic cyc(input bit r, input bit rq, input bit we, input bit ds,
                     input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input bit f, input bit dk, input logic [31:0] la);
    int n;
    bit mh, e_full, e_stall, e_ack;
    logic [3:0]  e_mask;
    logic [31:0] e_data, e_da, e_dd;
    logic [3:0]  e_ds;
    @(negedge clk);
    rst = r; req = rq; w_en = we; dsel_i = ds; addr = a; wdata = d; sel = s;
    fence = f; dack = dk; ld_addr = la;
    #1;
    n = q.size();
    e_full = (n == DEPTH);
    mh = 1'b0;
`ifdef STB_COALESCE_EN
    mh = (n >= 2) && (q[n-1].a[31:2] == a[31:2]);
`endif
    e_stall = f | (e_full & ~mh);
    e_ack   = rq & we & ds & ~e_stall & ~r;
    e_mask = '0; e_data = '0;
    for (int k = 0; k < n; k++)
      if (q[k].a[31:2] == la[31:2])
        for (int b = 0; b < 4; b++)
          if (q[k].s[b]) begin e_mask[b] = 1'b1; e_data[8*b +: 8] = q[k].d[8*b +: 8]; end
    e_da = (n > 0) ? q[0].a : '0;
    e_dd = (n > 0) ? q[0].d : '0;
    e_ds = (n > 0) ? q[0].s : '0;
    chk("ack", ack, e_ack);
    chk("stall", stall, e_stall);
    chk("count", count, n);
    chk("empty", dc_empty, n == 0);
    chk("dc_req", {dc_req, dc_w_en, dsel_o}, (n > 0) ? 3'b111 : 3'b000);
    chk("dc_addr", dc_addr, e_da);
    chk("dc_wdata", dc_wdata, e_dd);
    chk("dc_sel", dc_sel, e_ds);
    chk("fwd_mask", fwd_mask, e_mask);
    chk("fwd_data", fwd_data, e_data);
    o_fwd_data = fwd_data; o_fwd_mask = fwd_mask; o_count = count; o_ack = ack;
    o_stall = stall; o_empty = dc_empty; o_req = dc_req; o_dc_addr = dc_addr;
    if (r) q.delete();
    else begin
      if (e_ack) begin
        if (mh) begin
          for (int b = 0; b < 4; b++) if (s[b]) q[n-1].d[8*b +: 8] = d[8*b +: 8];
          q[n-1].s = q[n-1].s | s;
        end else q.push_back('{a: a, d: d, s: s});
      end
      if (n > 0 && dk) void'(q.pop_front());
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input bit dk);
    cyc(0, 1, 1, 1, a, d, s, 0, dk, a);
  endtask

  task automatic idle(input bit dk, input logic [31:0] la);
    cyc(0, 0, 1, 1, 32'h0, 32'h0, 4'h0, 0, dk, la);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) idle(1, 32'h0);
    chk("drain_bound", q.size(), 0);
  endtask

  bit f_on;

  initial begin
    rst = 1; req = 0; w_en = 0; dsel_i = 0; addr = 0; wdata = 0; sel = 0;
    fence = 0; dack = 0; ld_addr = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    idle(0, 32'h0);
    chk("rst_empty", o_empty, 1'b1);
    chk("rst_count", o_count, 0);

    // in-order drain of four stores
    push(32'h1000, 32'hAAAABBBB, 4'hF, 0);
    push(32'h1004, 32'hCCCCDDDD, 4'hF, 0);
    push(32'h1008, 32'hBBBBAAAA, 4'hF, 0);
    push(32'h100C, 32'hFFFFDDDD, 4'hF, 0);
    idle(1, 32'h0);
    chk("four_count", o_count, 4);
    chk("order0", o_dc_addr, 32'h1000);
    idle(1, 32'h0); chk("order1", o_dc_addr, 32'h1004);
    idle(1, 32'h0); chk("order2", o_dc_addr, 32'h1008);
    idle(1, 32'h0); chk("order3", o_dc_addr, 32'h100C);
    idle(0, 32'h0); chk("four_empty", o_empty, 1'b1);

    // fill, then full with a pop in the same cycle
    for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'(i*16), $urandom, 4'hF, 0);
    idle(0, 32'h0);
    chk("full_stall", o_stall, 1'b1);
    chk("full_count", o_count, 8);
    push(32'h1800, 32'h12345678, 4'hF, 1);
    chk("full_pop_noack", o_ack, 1'b0);
    push(32'h1800, 32'h12345678, 4'hF, 0);
    chk("after_pop_ack", o_ack, 1'b1);
    chk("after_pop_count", o_count, 7);
    drain();

    // youngest-wins byte merge and a miss
    push(32'h2000, 32'h11223344, 4'hF, 0);
    push(32'h2000, 32'hAABBCCDD, 4'h3, 0);
    idle(0, 32'h2002);
    chk("fwd_merge_mask", o_fwd_mask, 4'hF);
    chk("fwd_merge_data", o_fwd_data, 32'h1122CCDD);
    idle(0, 32'h3000);
    chk("fwd_miss_mask", o_fwd_mask, 4'h0);
    chk("fwd_miss_data", o_fwd_data, 32'h0);
    drain();

    // fence with acks every other cycle
    for (int i = 0; i < 3; i++) push(32'h4000 + 32'(i*4), $urandom, 4'hF, 0);
    for (int i = 0; i < 12 && q.size() > 0; i++) begin
      cyc(0, 1, 1, 1, 32'h5000, 32'h1, 4'hF, 1, i[0], 32'h0);
      chk("fence_noack", o_ack, 1'b0);
    end
    chk("fence_drained", q.size(), 0);
    idle(0, 32'h0);
    chk("fence_drop_stall", o_stall, 1'b0);

    // coalescing into the youngest entry
    push(32'h1000, 32'h1, 4'hF, 0);
    push(32'h1010, 32'h2, 4'hF, 0);
    push(32'h2004, 32'h000000AA, 4'h1, 0);
    push(32'h2004, 32'h00BB0000, 4'h4, 0);
    idle(0, 32'h2004);
`ifdef STB_COALESCE_EN
    chk("coal_count", o_count, 3);
`else
    chk("coal_count", o_count, 4);
`endif
    chk("coal_mask", o_fwd_mask, 4'h5);
    chk("coal_data", o_fwd_data, 32'h00BB00AA);

    // reset mid-drain with a dcache ack in flight
    idle(1, 32'h0);
    cyc(1, 1, 1, 1, 32'h6000, 32'h9, 4'hF, 0, 1, 32'h0);
    idle(0, 32'h0);
    chk("midrst_empty", o_empty, 1'b1);
    chk("midrst_req", o_req, 1'b0);

    // random traffic around a few words so forwarding and merging hit often
    f_on = 0;
    for (int i = 0; i < 3000; i++) begin
      if (f_on && q.size() == 0 && $urandom_range(0, 2) == 0) f_on = 0;
      else if (!f_on && $urandom_range(0, 39) == 0) f_on = 1;
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
          $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
          32'h2000 + 32'($urandom_range(0, 15)), $urandom, 4'($urandom),
          f_on, $urandom_range(0, 1) == 1, 32'h2000 + 32'($urandom_range(0, 15)));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/store_buffer_fwd.md
Name: store_buffer_fwd

Overview:
Parametrised next-generation store buffer between the LSU/MMU and the dcache. It accepts stores from the LSU into a circular FIFO of DEPTH entries and drains them in order to the dcache over a req/ack handshake. It adds store-to-load forwarding with per-byte youngest-wins merging and a fence/drain control. Optionally, it coalesces same-word stores into the youngest entry.

Parameters:
ADDR_WIDTH, 32, address width.
DATA_WIDTH, 32, store data width; multiple of 8.
BYTE_SEL_WIDTH, DATA_WIDTH/8, byte-enable width.
DEPTH, 8, number of entries; power of two, at least 2.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
lsummu2stb_addr  in  ADDR_WIDTH  store address (byte address).
lsummu2stb_wdata  in  DATA_WIDTH  store data.
lsummu2stb_sel_byte  in  BYTE_SEL_WIDTH  store byte enables.
lsummu2stb_w_en  in  1  write enable.
lsummu2stb_req  in  1  store valid.
dmem_sel_i  in  1  data-memory select; a store is a candidate only when this is high.
lsummu2stb_fence  in  1  drain request.
lsummu2stb_ld_addr  in  ADDR_WIDTH  load lookup address.
stb2lsummu_ack  out  1  store accepted this cycle.
stb2lsummu_stall  out  1  buffer cannot accept a store.
stb2lsummu_fwd_mask  out  BYTE_SEL_WIDTH  bytes supplied by the buffer.
stb2lsummu_fwd_data  out  DATA_WIDTH  forwarded bytes.
stb2dcache_addr  out  ADDR_WIDTH  head entry address.
stb2dcache_wdata  out  DATA_WIDTH  head entry data.
stb2dcache_sel_byte  out  BYTE_SEL_WIDTH  head entry byte enables.
stb2dcache_w_en  out  1  write enable to the dcache.
stb2dcache_req  out  1  head entry valid.
stb2dcache_empty  out  1  buffer empty.
dmem_sel_o  out  1  dcache select.
stb_count  out  $clog2(DEPTH)+1  occupancy.
dcache2stb_ack  in  1  dcache consumed the head entry.

Behaviour:
- Storage: entry array, head and tail pointers of $clog2(DEPTH) bits each (wrap modulo DEPTH), count register. full = (count==DEPTH); empty = (count==0).
- push = lsummu2stb_req & lsummu2stb_w_en & dmem_sel_i & ~stb2lsummu_stall.
- stb2lsummu_ack = push. It is combinational, so an acked store is written at the same clock edge. The LSU drops or changes the request after seeing ack.
- stb2lsummu_stall = full | lsummu2stb_fence.
- Fence: while lsummu2stb_fence is high, no stores are accepted and draining continues. The LSU holds fence until stb2dcache_empty is high.
- Drain: stb2dcache_req, stb2dcache_w_en and dmem_sel_o all equal ~empty. The addr, wdata and sel_byte outputs come from the head entry and stay stable until dcache2stb_ack.
- pop = stb2dcache_req & dcache2stb_ack. The head advances at that edge; the next entry is presented the following cycle and req stays high if entries remain.
- An ack while empty is ignored.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Full with a pop in the same cycle: the store is still stalled that cycle. There is no same-cycle bypass.
- Forwarding is combinational over all valid entries, including the head being drained. Word match compares addr[ADDR_WIDTH-1:$clog2(BYTE_SEL_WIDTH)].
  - For each byte, the youngest matching entry with that sel bit set supplies the data.
  - fwd_mask is the OR of the covered bytes; uncovered data bytes are 0.
  - A store pushed in the current cycle is not visible until the next cycle.
- Reset values: all entries invalid, pointers and count 0. stb2dcache_empty=1. req, w_en, dmem_sel_o, ack, stall and fwd_mask are 0. Data and address outputs are 0.
- Reset mid-operation discards all pending stores at that edge; any in-flight dcache ack in that cycle is ignored.

Optional Feature:
Macro: STB_COALESCE_EN.
- Defined: a push whose word address equals the youngest entry's word address, with count>=2 (youngest is not the head), merges into that entry instead of allocating.
  - Enabled bytes are overwritten and sel becomes the OR of old and new.
  - count is unchanged.
  - The merge is permitted even when full; stall is then fence | (full & ~merge_hit).
- Undefined: every push allocates a new entry. The merge logic and the merge_hit term are absent.

Decomposition:
- Package store_buffer_pkg holds:
  - struct stb_entry_t {addr, data, sel};
  - localparams PTR_W = $clog2(DEPTH) and the word-offset width;
  - function word_match().
- Sub-module stb_fwd_merge: purely combinational per-byte youngest-wins selection over the entry array, with head pointer and count as inputs.

Test Plan:
- Reset, then push 0x1000/AAAABBBB, 0x1004/CCCCDDDD, 0x1008/BBBBAAAA, 0x100C/FFFFDDDD (sel 1111), ack each one cycle later → pushes acked in the same cycle, count=4, dcache sees them in that order, empty=1 after the 4th ack.
- Push DEPTH stores with no dcache ack → stall=1 at count=8. Push plus ack in the same cycle → ack=0, count=7, then accepted next cycle.
- Push 0x2000/11223344 sel 1111, then 0x2000/AABBCCDD sel 0011, lookup 0x2002 → fwd_mask=1111, fwd_data=1122CCDD.
- Lookup 0x3000 with no matching entry → fwd_mask=0000, fwd_data=0.
- Fence with 3 entries and acks every other cycle → stall=1, no pushes accepted, empty after 3 pops. Drop fence → stall=0.
- With STB_COALESCE_EN: two entries present, push 0x2004 sel 0001 then 0x2004 sel 0100 → count=3, youngest sel=0101. Reset mid-drain → empty=1 and req=0 after that edge.
